// File: rtl/counter_gidc_checker.sv
// Lock-and-track monitor for a 0..MAX..0 triangle count stream; flags deviations, counts periods.
// Registered outputs, one cycle after the sampled edge; never stalls (sample_en=0 just holds state).
module counter_gidc_checker #(
   parameter int W      = 3,
   parameter int LOCK_N = 4,
   parameter int ERRW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sample_en,
   input  logic [W-1:0]    count,
   output logic            locked,
   output logic            dir,
   output logic            err,
   output logic [ERRW-1:0] err_cnt,
   output logic            cycle_done,
   output logic [15:0]     period_cnt
);

   localparam logic [W-1:0]    MAX     = '1;
   localparam logic [W-1:0]    ZERO    = '0;
   localparam logic [W-1:0]    ONE     = W'(1);
   localparam logic [W:0]      ONE_EXT = (W + 1)'(1);
   localparam logic [3:0]      LOCK_T  = LOCK_N[3:0];
   localparam logic [ERRW-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      ACQ    = 2'd0,
      DIRSEL = 2'd1,
      SYNC   = 2'd2,
      LOCK   = 2'd3
   } state_t;

   state_t          state, state_nx;
   logic [W-1:0]    prev, prev_nx;
   logic [3:0]      match, match_nx;
   logic            dir_nx, locked_nx, err_nx, cycle_done_nx;
   logic [ERRW-1:0] err_cnt_nx;
   logic [15:0]     period_cnt_nx;

   logic            step_up;
   logic [W-1:0]    exp_val;
   logic            hit;
   logic            dir_after;
   logic            is_up;
   logic            is_dn;
   logic [3:0]      match_inc;

   // Endpoints force the step direction, so 0->MAX and MAX->0 can never be a hit.
   always_comb begin
      step_up = dir;
      if (prev == ZERO) begin
         step_up = 1'b1;
      end else if (prev == MAX) begin
         step_up = 1'b0;
      end
      exp_val   = step_up ? (prev + ONE) : (prev - ONE);
      hit       = (count == exp_val);
      dir_after = step_up;
      if (count == ZERO) begin
         dir_after = 1'b1;
      end else if (count == MAX) begin
         dir_after = 1'b0;
      end
      is_up     = ({1'b0, count} == ({1'b0, prev} + ONE_EXT));
      is_dn     = (prev != ZERO) && (count == (prev - ONE));
      match_inc = match + 4'd1;
   end

   always_comb begin
      state_nx      = state;
      prev_nx       = prev;
      match_nx      = match;
      dir_nx        = dir;
      locked_nx     = locked;
      err_nx        = 1'b0;
      cycle_done_nx = 1'b0;
      err_cnt_nx    = err_cnt;
      period_cnt_nx = period_cnt;

      if (sample_en) begin
         prev_nx = count;
         case (state)
            ACQ: begin
               if (count == ZERO) begin
                  dir_nx   = 1'b1;
                  state_nx = SYNC;
               end else if (count == MAX) begin
                  dir_nx   = 1'b0;
                  state_nx = SYNC;
               end else begin
                  state_nx = DIRSEL;
               end
            end
            DIRSEL: begin
               if (is_up || is_dn) begin
                  dir_nx   = is_up;
                  match_nx = 4'd1;
                  // A single-transition lock threshold is already satisfied here.
                  if (LOCK_T <= 4'd1) begin
                     state_nx  = LOCK;
                     locked_nx = 1'b1;
                  end else begin
                     state_nx = SYNC;
                  end
               end
            end
            SYNC: begin
               if (hit) begin
                  match_nx = match_inc;
                  dir_nx   = dir_after;
                  if (match_inc >= LOCK_T) begin
                     state_nx  = LOCK;
                     locked_nx = 1'b1;
                  end
               end else begin
                  match_nx = 4'd0;
                  state_nx = DIRSEL;
               end
            end
            LOCK: begin
               if (hit) begin
                  dir_nx = dir_after;
                  if ((prev == ONE) && !dir && (count == ZERO)) begin
                     cycle_done_nx = 1'b1;
                     if (period_cnt != 16'hFFFF) begin
                        period_cnt_nx = period_cnt + 16'd1;
                     end
                  end
               end else begin
                  err_nx    = 1'b1;
                  locked_nx = 1'b0;
                  match_nx  = 4'd0;
                  state_nx  = DIRSEL;
                  if (err_cnt != ERR_MAX) begin
                     err_cnt_nx = err_cnt + ERRW'(1);
                  end
               end
            end
            default: begin
               state_nx = ACQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ACQ;
         prev       <= '0;
         match      <= 4'd0;
         dir        <= 1'b1;
         locked     <= 1'b0;
         err        <= 1'b0;
         cycle_done <= 1'b0;
         err_cnt    <= '0;
         period_cnt <= 16'd0;
      end else begin
         state      <= state_nx;
         prev       <= prev_nx;
         match      <= match_nx;
         dir        <= dir_nx;
         locked     <= locked_nx;
         err        <= err_nx;
         cycle_done <= cycle_done_nx;
         err_cnt    <= err_cnt_nx;
         period_cnt <= period_cnt_nx;
      end
   end

endmodule

// File: tb/tb_counter_gidc_checker.sv
// Scoreboard bench for counter_gidc_checker (W=3): directed streams push expectations, a monitor checks.
module tb_counter_gidc_checker;

   logic       clk;
   logic       rst;
   logic       sample_en;
   logic [2:0] count;
   logic       locked;
   logic       dir;
   logic       err;
   logic [7:0] err_cnt;
   logic       cycle_done;
   logic [15:0] period_cnt;

   typedef struct {
      int v;
      int lk;
      int dr;
      bit er;
      bit cd;
      int ec;
      int pc;
   } exp_t;

   exp_t q[$];
   int   nchk  = 0;
   int   nfail = 0;
   int   ec_m  = 0;
   int   pc_m  = 0;
   int   nsmp  = 0;

   counter_gidc_checker #(.W(3), .LOCK_N(4), .ERRW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .sample_en  (sample_en),
      .count      (count),
      .locked     (locked),
      .dir        (dir),
      .err        (err),
      .err_cnt    (err_cnt),
      .cycle_done (cycle_done),
      .period_cnt (period_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      nchk++;
      if (got != want) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // lk/dr of -1 leave that field unchecked for this sample.
   task automatic smp(input int v, input int lk, input int dr, input bit er, input bit cd);
      exp_t e;
      @(posedge clk);
      #1;
      sample_en = 1'b1;
      count     = v[2:0];
      if (er && ec_m != 255) ec_m++;
      if (cd && pc_m != 65535) pc_m++;
      e.v  = v;
      e.lk = lk;
      e.dr = dr;
      e.er = er;
      e.cd = cd;
      e.ec = ec_m;
      e.pc = pc_m;
      q.push_back(e);
      nsmp++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         sample_en = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b0;
      sample_en = 1'b0;
      #1;
      chk("reset locked", locked, 0);
      chk("reset dir", dir, 1);
      chk("reset err", err, 0);
      chk("reset err_cnt", err_cnt, 0);
      chk("reset cycle_done", cycle_done, 0);
      chk("reset period_cnt", period_cnt, 0);
      ec_m = 0;
      pc_m = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic int tri_val(input int i);
      int p;
      p = i % 14;
      return (p <= 7) ? p : 14 - p;
   endfunction

   function automatic int tri_dir(input int i);
      int v;
      v = tri_val(i);
      if (v == 0) return 1;
      if (v == 7) return 0;
      return ((i % 14) < 7) ? 1 : 0;
   endfunction

   // Monitor: a sample taken on an edge is judged after that edge; idle edges must be quiet.
   initial begin
      exp_t e;
      bit   en_d;
      forever begin
         @(posedge clk);
         en_d = sample_en && rst;
         @(negedge clk);
         if (en_d) begin
            if (q.size() == 0) begin
               chk("scoreboard underflow", 1, 0);
            end else begin
               e = q.pop_front();
               chk($sformatf("err v=%0d", e.v), err, e.er);
               chk($sformatf("cycle_done v=%0d", e.v), cycle_done, e.cd);
               chk($sformatf("err_cnt v=%0d", e.v), err_cnt, e.ec);
               chk($sformatf("period_cnt v=%0d", e.v), period_cnt, e.pc);
               if (e.lk >= 0) chk($sformatf("locked v=%0d", e.v), locked, e.lk);
               if (e.dr >= 0) chk($sformatf("dir v=%0d", e.v), dir, e.dr);
            end
         end else begin
            chk("idle err", err, 0);
            chk("idle cycle_done", cycle_done, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no end, expected summary");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      sample_en = 1'b0;
      count     = 3'd0;
      do_reset();

      // Clean stream: lock on count=4, three completed periods.
      for (int i = 0; i < 43; i++) begin
         smp(tri_val(i), (i >= 4) ? 1 : 0, tri_dir(i), 1'b0, (i >= 14) && (i % 14 == 0));
      end

      // Glitch while ascending: 5 instead of 3, then clean resync.
      smp(1, 1, 1, 1'b0, 1'b0);
      smp(2, 1, 1, 1'b0, 1'b0);
      smp(5, 0, -1, 1'b1, 1'b0);
      smp(4, 0, 0, 1'b0, 1'b0);
      smp(5, 0, -1, 1'b0, 1'b0);
      smp(6, 0, 1, 1'b0, 1'b0);
      smp(7, 0, 0, 1'b0, 1'b0);
      smp(6, 0, 0, 1'b0, 1'b0);
      smp(5, 1, 0, 1'b0, 1'b0);
      smp(4, 1, 0, 1'b0, 1'b0);
      idle(1);
      do_reset();

      // Gapped clean stream: same results counted in samples.
      for (int i = 0; i < 29; i++) begin
         smp(tri_val(i), (i >= 4) ? 1 : 0, tri_dir(i), 1'b0, (i >= 14) && (i % 14 == 0));
         idle(1 + (i % 3));
      end
      do_reset();

      // Mid-sequence start, descending.
      smp(5, 0, -1, 1'b0, 1'b0);
      smp(4, 0, 0, 1'b0, 1'b0);
      smp(3, 0, 0, 1'b0, 1'b0);
      smp(2, 0, 0, 1'b0, 1'b0);
      smp(1, 1, 0, 1'b0, 1'b0);
      smp(0, 1, 1, 1'b0, 1'b1);

      // Endpoint wrap 7 -> 0 is an error; resync upward.
      for (int v = 1; v <= 6; v++) smp(v, 1, 1, 1'b0, 1'b0);
      smp(7, 1, 0, 1'b0, 1'b0);
      smp(0, 0, -1, 1'b1, 1'b0);
      smp(1, 0, 1, 1'b0, 1'b0);
      smp(2, 0, 1, 1'b0, 1'b0);
      smp(3, 0, 1, 1'b0, 1'b0);
      smp(4, 1, 1, 1'b0, 1'b0);

      // 300 locked mismatches: err_cnt saturates at 255, err keeps pulsing.
      for (int k = 0; k < 300; k++) begin
         smp(0, 0, -1, 1'b1, 1'b0);
         smp(1, 0, 1, 1'b0, 1'b0);
         smp(2, 0, 1, 1'b0, 1'b0);
         smp(3, 0, 1, 1'b0, 1'b0);
         smp(4, 1, 1, 1'b0, 1'b0);
      end
      smp(5, 1, 1, 1'b0, 1'b0);
      smp(6, 1, 1, 1'b0, 1'b0);
      smp(7, 1, 0, 1'b0, 1'b0);
      idle(1);
      do_reset();

      // Reacquire from MAX after reset.
      smp(7, 0, 0, 1'b0, 1'b0);
      smp(6, 0, 0, 1'b0, 1'b0);
      smp(5, 0, 0, 1'b0, 1'b0);
      smp(4, 0, 0, 1'b0, 1'b0);
      smp(3, 1, 0, 1'b0, 1'b0);
      idle(3);

      chk("scoreboard drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
      $finish;
   end

endmodule
